// File: rtl/rom_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_arb_pkg : shared types and helpers for the ROM request arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rom_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // A single requester still needs a 1-bit grant index.
    function automatic int grant_idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_arb_pick : combinational winner selection for rom_rr_arbiter     |
// | Round-robin by default; fixed priority when ROM_ARB_FIXED_PRIO_EN.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rom_arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_gnt_oh,
    output logic [IDX_W-1:0]   o_gnt_idx,
    output logic               o_gnt_any
);

    always_comb begin
        int cand;
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        cand      = 0;
`ifdef ROM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_gnt_any && i_req[i]) begin
                o_gnt_any   = 1'b1;
                o_gnt_oh[i] = 1'b1;
                o_gnt_idx   = IDX_W'(i);
            end
        end
`else
        // Search starts just after the last winner and wraps around.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(i_last) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!o_gnt_any && i_req[cand]) begin
                o_gnt_any      = 1'b1;
                o_gnt_oh[cand] = 1'b1;
                o_gnt_idx      = IDX_W'(cand);
            end
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/rom_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_rr_arbiter : shares one 1-cycle synchronous ROM among NUM_REQ    |
// | requesters. Define ROM_ARB_FIXED_PRIO_EN for fixed priority.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rom_rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic [ADDR_WIDTH-1:0]         rom_addr_o,
    input  logic [DATA_WIDTH-1:0]         rom_data_i,
    output logic                          busy_o
);

    localparam int IDX_W = grant_idx_width(NUM_REQ);

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    logic [IDX_W-1:0]       r_grant;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [IDX_W-1:0]       w_last;
    logic [NUM_REQ-1:0]     w_gnt_oh;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic                   w_gnt_any;
    logic                   w_accept;
    logic [NUM_REQ-1:0]     w_grant_oh;
    logic                   w_rsp_hs;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;

    rom_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req     (req_valid_i),
        .i_last    (w_last),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_gnt_any)
    );

`ifdef ROM_ARB_FIXED_PRIO_EN
    assign w_last = '0;
`else
    logic [IDX_W-1:0] r_last;

    // Reset to the top index so requester 0 is searched first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last <= IDX_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_last <= w_gnt_idx;
        end
    end

    assign w_last = r_last;
`endif

    assign w_accept = (r_state == ST_IDLE) && w_gnt_any;

    always_comb begin
        w_sel_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_oh[k]) begin
                w_sel_addr = w_sel_addr | req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_grant_oh[k] = (r_grant == IDX_W'(k));
        end
        w_rsp_hs = |(w_grant_oh & rsp_ready_i);
    end

    // Address is held after the read so the ROM output stays stable under backpressure.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grant <= '0;
            r_addr  <= '0;
        end else if (w_accept) begin
            r_grant <= w_gnt_idx;
            r_addr  <= w_sel_addr;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_gnt_any) w_next_state = ST_READ;
            ST_READ: w_next_state = ST_RESP;
            ST_RESP: if (w_rsp_hs) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Accept strobe is masked during reset so outputs drop to zero at once.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_data_o  = '0;
        busy_o      = (r_state != ST_IDLE);
        if (w_accept && !rst_i) begin
            req_ready_o = w_gnt_oh;
        end
        if (r_state == ST_RESP) begin
            rsp_valid_o = w_grant_oh;
            rsp_data_o  = rom_data_i;
        end
    end

    assign rom_addr_o = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_rom_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rom_rr_arbiter : self-checking bench for rom_rr_arbiter           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rom_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N-1:0]    rsp_ready = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data = '0;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    rom_rr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rom_addr_o  (rom_addr),
        .rom_data_i  (rom_data),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // ROM contents: word[i] = i ^ 8'hA5, registered read.
    logic [DW-1:0] rom_mem [256];
    initial for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef ROM_ARB_FIXED_PRIO_EN
        for (int c = 0; c < N; c++) if (v[c]) return c;
`else
        for (int i = 1; i <= N; i++) if (v[(last + i) % N]) return (last + i) % N;
`endif
        return 0;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Transaction-level model: accept, then response visible two cycles later until handshake.
    bit            m_busy  = 1'b0;
    int            m_age   = 0;
    int            m_grant = 0;
    int            m_last  = N - 1;
    logic [AW-1:0] m_addr  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_age = 0; m_grant = 0; m_last = N - 1; m_addr = '0;
        end else if (!m_busy) begin
            if (req_valid != '0) begin
                m_grant = pick(req_valid, m_last);
                m_last  = m_grant;
                m_addr  = req_addr[m_grant*AW +: AW];
                m_busy  = 1'b1;
                m_age   = 1;
            end
        end else if (m_age < 2) begin
            m_age = 2;
        end else if (rsp_ready[m_grant]) begin
            m_busy = 1'b0;
        end
    end

    logic [N-1:0]  e_ready, e_valid;
    logic [DW-1:0] e_data;

    always @(negedge clk) begin
        e_ready = '0; e_valid = '0; e_data = '0;
        if (!rst) begin
            if (!m_busy && req_valid != '0) e_ready[pick(req_valid, m_last)] = 1'b1;
            if (m_busy && m_age >= 2) begin
                e_valid[m_grant] = 1'b1;
                e_data = m_addr ^ 8'hA5;
            end
        end
        chk("model_req_ready", req_ready, e_ready);
        chk("model_rsp_valid", rsp_valid, e_valid);
        chk("model_rsp_data",  rsp_data,  e_data);
        chk("model_rom_addr",  rom_addr,  m_addr);
        chk("model_busy",      busy,      m_busy);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int k, input logic [AW-1:0] a);
        req_addr[k*AW +: AW] = a;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!busy) break;
            tick();
        end
        chk("drain_idle", busy, 1'b0);
        tick();
    endtask

    int g_idx[$];
    int g_cyc[$];
    logic [DW-1:0] d_seen[$];

    task automatic run_continuous(input int cycles);
        logic [DW-1:0] prev_data;
        g_idx.delete(); g_cyc.delete(); d_seen.delete();
        prev_data = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g_idx.push_back(oh2idx(req_ready));
                g_cyc.push_back(c);
            end
            if (rsp_valid != '0) d_seen.push_back(rsp_data);
            tick();
        end
    endtask

    initial begin
        int exp_g[5];
        int exp_d[4];
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_ready", req_ready, 4'b0000);
        chk("reset_valid", rsp_valid, 4'b0000);
        chk("reset_busy",  busy, 1'b0);
        chk("reset_addr",  rom_addr, 8'h00);
        chk("reset_data",  rsp_data, 8'h00);
        tick();

        // Single request, requester 2
        rsp_ready = '1;
        set_addr(2, 8'h10);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_read_no_valid", rsp_valid, 4'b0000);
        chk("t1_rom_addr", rom_addr, 8'h10);
        tick();
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 4'b0100);
        chk("t1_rsp_data",  rsp_data, 8'hB5);
        tick();
        @(negedge clk);
        chk("t1_idle", busy, 1'b0);
        tick();

        // All four requesting continuously
        do_reset();
        for (int k = 0; k < N; k++) set_addr(k, 8'(k + 1));
        rsp_ready = '1;
        req_valid = '1;
        run_continuous(15);
        drain();
        exp_g = '{0, 1, 2, 3, 0};
        exp_d = '{8'hA4, 8'hA7, 8'hA6, 8'hA1};
        chk("t2_grant_count", g_idx.size(), 5);
        for (int i = 0; i < 5 && i < g_idx.size(); i++) chk("t2_grant_order", g_idx[i], exp_g[i]);
        for (int i = 1; i < g_cyc.size(); i++) chk("t2_spacing", g_cyc[i] - g_cyc[i-1], 3);
        for (int i = 0; i < 4 && i < d_seen.size(); i++) chk("t2_data", d_seen[i], exp_d[i]);

        // Backpressure on requester 1 while requester 0 waits
        do_reset();
        rsp_ready = '0;
        set_addr(1, 8'h20);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("t3_ready1", req_ready, 4'b0010);
        tick();
        set_addr(0, 8'h30);
        req_valid = 4'b0001;
        rsp_ready = 4'b0001;
        @(negedge clk);
        chk("t3_busy_block", req_ready, 4'b0000);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", rsp_valid, 4'b0010);
            chk("t3_hold_data",  rsp_data, 8'h85);
            chk("t3_hold_noacc", req_ready, 4'b0000);
            tick();
        end
        rsp_ready = 4'b0011;
        @(negedge clk);
        chk("t3_hs_valid", rsp_valid, 4'b0010);
        tick();
        @(negedge clk);
        chk("t3_ready0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        chk("t3_rsp0_valid", rsp_valid, 4'b0001);
        chk("t3_rsp0_data",  rsp_data, 8'h95);
        tick();
        drain();

        // Reset during READ
        do_reset();
        rsp_ready = '1;
        set_addr(2, 8'h40);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("t4_async_busy", busy, 1'b0);
        chk("t4_async_addr", rom_addr, 8'h00);
        chk("t4_async_valid", rsp_valid, 4'b0000);
        set_addr(0, 8'h05);
        set_addr(1, 8'h06);
        req_valid = 4'b0011;
        @(negedge clk);
        chk("t4_in_reset_ready", req_ready, 4'b0000);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_first_winner", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0010;
        tick();
        @(negedge clk);
        chk("t4_rsp_valid", rsp_valid, 4'b0001);
        chk("t4_rsp_data",  rsp_data, 8'hA0);
        tick();
        @(negedge clk);
`ifdef ROM_ARB_FIXED_PRIO_EN
        chk("t4_second", req_ready, 4'b0010);
`else
        chk("t4_second", req_ready, 4'b0010);
`endif
        tick();
        drain();

        // Wrap-around from last grant 3
        do_reset();
        rsp_ready = '1;
        set_addr(3, 8'h77);
        set_addr(0, 8'h01);
        req_valid = 4'b1000;
        @(negedge clk);
        chk("t5_ready3", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        tick();
        tick();
        req_valid = 4'b1001;
        @(negedge clk);
        chk("t5_wrap_to0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b1000;
        tick();
        tick();
        @(negedge clk);
        chk("t5_then3", req_ready, 4'b1000);
        tick();
        drain();

        // Requesters 0 and 2 continuously
        do_reset();
        rsp_ready = '1;
        set_addr(0, 8'h00);
        set_addr(2, 8'h02);
        req_valid = 4'b0101;
        run_continuous(12);
        drain();
        chk("t6_count", g_idx.size(), 4);
        for (int i = 0; i < g_idx.size(); i++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            chk("t6_fixed_grant", g_idx[i], 0);
`else
            chk("t6_rr_grant", g_idx[i], (i % 2 == 0) ? 0 : 2);
`endif
        end
        for (int i = 1; i < g_cyc.size(); i++) chk("t6_spacing", g_cyc[i] - g_cyc[i-1], 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
- Shares one synchronous single-port ROM (1-cycle registered read, `clk_i` domain) between NUM_REQ independent requesters.
- Per-requester valid/ready handshakes on the request and response sides.
- Selects the requester round-robin, drives the ROM address, waits out the ROM read latency, and returns the data to the granted requester with backpressure.
- Sits between the ROM instance and its consumers, e.g. an AXI ROM front-end plus a boot sequencer.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, ROM word width; must match the ROM.
- ADDR_WIDTH, 8, ROM address width; must match the ROM.

Ports:
- clk_i  in  1  single clock; the ROM shares it.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester read request.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready_o  out  NUM_REQ  one-hot accept strobe.
- rsp_valid_o  out  NUM_REQ  one-hot response valid.
- rsp_ready_i  in  NUM_REQ  per-requester response ready.
- rsp_data_o  out  DATA_WIDTH  shared response data; qualified by rsp_valid_o.
- rom_addr_o  out  ADDR_WIDTH  to ROM addr_i.
- rom_data_i  in  DATA_WIDTH  from ROM data_o.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: state=IDLE; req_ready_o=0, rsp_valid_o=0, rom_addr_o=0, busy_o=0; grant index=0; last-grant pointer=NUM_REQ-1, so requester 0 wins first.
- Requester rule: hold req_valid_i and req_addr_i stable until the req_ready_o handshake. Dropping valid before ready is illegal. The arbiter never reads an address it has not accepted.
- FSM states: IDLE, READ, RESP.
- IDLE:
  - If any req_valid_i, pick winner g by round-robin: first set bit searching (last+1) upward, wrapping modulo NUM_REQ.
  - Assert req_ready_o[g] combinationally in this cycle only.
  - At the clock edge: register grant=g, rom_addr_o=req_addr_i[g], last=g; go to READ.
  - No valid → stay in IDLE; req_ready_o=0.
- READ:
  - rom_addr_o is stable; the ROM samples it at the end of this cycle. Unconditionally go to RESP.
- RESP:
  - rsp_valid_o[grant]=1; rsp_data_o=rom_data_i, which stays stable because rom_addr_o is held.
  - On rsp_ready_i[grant]=1 at the edge, go to IDLE. Otherwise stay in RESP with outputs held.
  - rsp_ready_i of non-granted requesters is ignored.
- Latency and throughput:
  - Accept edge E0; rsp_valid_o high in the cycle after edge E1 (2 cycles after accept).
  - Minimum 3 cycles per transaction.
- rsp_data_o: driven only in RESP, 0 otherwise.
- Simultaneous events:
  - A new request that arrives while busy waits; it is not accepted until IDLE.
  - The pointer updates only on accept.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,...,NUM_REQ-1,0.
- Wrap-around: pointer NUM_REQ-1 → search starts at 0.
- Reset mid-operation: immediate return to reset values. An in-flight response is lost and the requester must re-issue.
- Address width: no range check is needed; the ROM depth is 2**ADDR_WIDTH.

Optional Feature:
- Macro: ROM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest requester index wins; the last-grant pointer is not implemented.
- Undefined (default): round-robin as described.
- Handshake, FSM and latency are identical in both modes.

Decomposition:
- Package rom_arb_pkg contains:
  - state enum typedef (IDLE, READ, RESP), 2-bit encoding;
  - function for the grant index width: $clog2(NUM_REQ), minimum 1.
- Sub-module rom_arb_pick: combinational picker.
  - Inputs: request vector and last pointer. Outputs: one-hot grant and index.
  - Contains the fixed/round-robin `ifdef` so the FSM stays mode-agnostic.

Test Plan:
1. ROM init word[i]=i^8'hA5. Single request: req 2 addr 8'h10 → req_ready_o=4'b0100 at accept; rsp_valid_o=4'b0100 two cycles later; rsp_data_o=8'hB5.
2. All four valid continuously, addrs 1,2,3,4, rsp_ready=1 → grant order 0,1,2,3,0; one transaction every 3 cycles; data A4,A7,A6,A1.
3. Backpressure: req 1 addr 8'h20, rsp_ready_i[1]=0 for 5 cycles → rsp_valid_o[1] and rsp_data_o=8'h85 held stable; req 0 pending is not accepted until after the handshake.
4. Reset asserted mid-READ → outputs zero asynchronously; after release, requester 0 wins first; the re-issued request completes normally.
5. Wrap-around: last grant 3, requests {0,3} → 0 granted; then {3} alone → 3 granted.
6. With ROM_ARB_FIXED_PRIO_EN, requests 0 and 2 continuous → 0 always granted; 2 starves; latency unchanged.
